// File: rtl/first_nios2_system_mem_checker.sv
// Avalon-MM memory self-test master: writes seed + i*GOLDEN over a word range, reads it back pipelined and counts mismatches.
// Optional build macro MEM_CHECKER_INVERT_PASS_EN adds a second pass that writes and checks the inverted pattern.
module first_nios2_system_mem_checker #(
    parameter int          ADDR_WIDTH  = 14,
    parameter int          MAX_PENDING = 4,
    parameter logic [31:0] GOLDEN      = 32'h9E3779B9
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   word_count_i,
    input  logic [31:0]           seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [15:0]           error_count_o,
    output logic [ADDR_WIDTH-1:0] first_error_addr_o,
    output logic [ADDR_WIDTH-1:0] avm_address_o,
    output logic                  avm_read_o,
    output logic                  avm_write_o,
    output logic [3:0]            avm_byteenable_o,
    output logic [31:0]           avm_writedata_o,
    input  logic                  avm_waitrequest_i,
    input  logic [31:0]           avm_readdata_i,
    input  logic                  avm_readdatavalid_i
);

    localparam int OW = $clog2(MAX_PENDING + 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] firstErr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   issueIdx_q;
    logic [ADDR_WIDTH:0]   respIdx_q;
    logic [31:0]           seed_q;
    logic [31:0]           pattern_q;
    logic [31:0]           expected_q;
    logic [OW-1:0]         outst_q;
    logic [15:0]           errCount_q;
    logic                  done_q;

    logic invertPass;
    logic lastPass;
    logic startAcc;
    logic wrAcc;
    logic rdAcc;
    logic rspValid;
    logic lastIssue;
    logic drainDone;
    logic mismatch;
    logic doneSet;

`ifdef MEM_CHECKER_INVERT_PASS_EN
    logic second_q;

    assign invertPass = second_q;
    assign lastPass   = second_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            second_q <= 1'b0;
        end else if (startAcc) begin
            second_q <= 1'b0;
        end else if (drainDone && !second_q) begin
            second_q <= 1'b1;
        end
    end
`else
    assign invertPass = 1'b0;
    assign lastPass   = 1'b1;
`endif

    assign startAcc  = (state_q == IDLE) && start_i;
    assign wrAcc     = avm_write_o && !avm_waitrequest_i;
    assign rdAcc     = avm_read_o && !avm_waitrequest_i;
    // Responses with nothing outstanding (e.g. left over from an aborted test) are discarded.
    assign rspValid  = avm_readdatavalid_i && (outst_q != '0);
    assign lastIssue = (issueIdx_q == count_q - (ADDR_WIDTH+1)'(1));
    assign drainDone = (state_q == DRAIN) &&
                       ((outst_q == '0) || ((outst_q == OW'(1)) && rspValid));
    assign mismatch  = rspValid && (avm_readdata_i != (expected_q ^ {32{invertPass}}));
    // The data path leaves DRAIN straight for IDLE so done rises one cycle after the final response.
    assign doneSet   = (state_q == DONE) || (drainDone && lastPass);

    assign busy_o             = (state_q != IDLE);
    assign done_o             = done_q;
    assign pass_o             = done_q && (errCount_q == 16'd0);
    assign error_count_o      = errCount_q;
    assign first_error_addr_o = firstErr_q;
    assign avm_write_o        = (state_q == WRITE);
    assign avm_read_o         = (state_q == READ) && (outst_q < OW'(MAX_PENDING));
    assign avm_address_o      = base_q + issueIdx_q[ADDR_WIDTH-1:0];
    assign avm_writedata_o    = pattern_q ^ {32{invertPass}};
    assign avm_byteenable_o   = 4'hF;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (word_count_i == '0) ? DONE : WRITE;
            WRITE:   if (wrAcc && lastIssue) state_d = READ;
            READ:    if (rdAcc && lastIssue) state_d = DRAIN;
            DRAIN:   if (drainDone) state_d = lastPass ? IDLE : WRITE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_q     <= '0;
            count_q    <= '0;
            seed_q     <= '0;
            issueIdx_q <= '0;
            respIdx_q  <= '0;
            pattern_q  <= '0;
            expected_q <= '0;
            outst_q    <= '0;
            errCount_q <= '0;
            firstErr_q <= '0;
            done_q     <= 1'b0;
        end else if (startAcc) begin
            base_q     <= base_addr_i;
            count_q    <= word_count_i;
            seed_q     <= seed_i;
            issueIdx_q <= '0;
            respIdx_q  <= '0;
            pattern_q  <= seed_i;
            expected_q <= seed_i;
            errCount_q <= '0;
            firstErr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (wrAcc) begin
                if (lastIssue) begin
                    issueIdx_q <= '0;
                    pattern_q  <= seed_q;
                end else begin
                    issueIdx_q <= issueIdx_q + (ADDR_WIDTH+1)'(1);
                    pattern_q  <= pattern_q + GOLDEN;
                end
            end
            if (rdAcc) begin
                issueIdx_q <= lastIssue ? '0 : issueIdx_q + (ADDR_WIDTH+1)'(1);
            end

            case ({rdAcc, rspValid})
                2'b10:   outst_q <= outst_q + OW'(1);
                2'b01:   outst_q <= outst_q - OW'(1);
                default: outst_q <= outst_q;
            endcase

            if (rspValid) begin
                respIdx_q  <= respIdx_q + (ADDR_WIDTH+1)'(1);
                expected_q <= expected_q + GOLDEN;
            end
            if (mismatch) begin
                if (errCount_q != 16'hFFFF) errCount_q <= errCount_q + 16'd1;
                if (errCount_q == 16'd0)    firstErr_q <= base_q + respIdx_q[ADDR_WIDTH-1:0];
            end

            // Rewind the response tracking when another pass follows.
            if (drainDone && !lastPass) begin
                respIdx_q  <= '0;
                expected_q <= seed_q;
            end
            if (doneSet) done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_first_nios2_system_mem_checker.sv
// Bench for first_nios2_system_mem_checker: behavioural Avalon slave with stalls, latency and corruption, plus a result model.
module tb_first_nios2_system_mem_checker;

    localparam int          AW    = 14;
    localparam int          MAXP  = 4;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] GOLD  = 32'h9E3779B9;
`ifdef MEM_CHECKER_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   wordCount;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [15:0]   errorCount;
    logic [AW-1:0] firstErrorAddr;
    logic [AW-1:0] avmAddress;
    logic          avmRead, avmWrite;
    logic [3:0]    avmByteEnable;
    logic [31:0]   avmWriteData;
    logic          avmWaitRequest;
    logic [31:0]   avmReadData;
    logic          avmReadDataValid;

    first_nios2_system_mem_checker #(
        .ADDR_WIDTH (AW),
        .MAX_PENDING(MAXP),
        .GOLDEN     (GOLD)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .start_i            (start),
        .base_addr_i        (baseAddr),
        .word_count_i       (wordCount),
        .seed_i             (seed),
        .busy_o             (busy),
        .done_o             (done),
        .pass_o             (pass),
        .error_count_o      (errorCount),
        .first_error_addr_o (firstErrorAddr),
        .avm_address_o      (avmAddress),
        .avm_read_o         (avmRead),
        .avm_write_o        (avmWrite),
        .avm_byteenable_o   (avmByteEnable),
        .avm_writedata_o    (avmWriteData),
        .avm_waitrequest_i  (avmWaitRequest),
        .avm_readdata_i     (avmReadData),
        .avm_readdatavalid_i(avmReadDataValid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Slave model state
    logic [31:0] mem [0:DEPTH-1];
    bit          corruptMap [0:DEPTH-1];
    bit          corruptAll = 1'b0;
    int          waitMode = 0;
    int          latency  = 1;
    int          rspDue[$];
    logic [31:0] rspData[$];
    int          wrCount = 0, rdCount = 0, maxInflight = 0;
    int          stableErr = 0, overlapErr = 0;
    int          firstCmdCyc = -1, lastRdvCyc = -1;
    bit          waitPhase = 1'b0;
    bit          prevStall = 1'b0;
    logic [AW-1:0] prevAddr;
    logic [31:0]   prevWd;
    logic          prevRd, prevWr;

    // Slave acts on the falling edge: the DUT's outputs are stable and its inputs settle before the next rising edge.
    always @(negedge clk) begin
        logic [31:0] rsp;
        if (rspDue.size() > 0 && rspDue[0] <= cyc) begin
            avmReadDataValid = 1'b1;
            avmReadData      = rspData.pop_front();
            void'(rspDue.pop_front());
            lastRdvCyc       = cyc;
        end else begin
            avmReadDataValid = 1'b0;
            avmReadData      = $urandom;
        end
        case (waitMode)
            1: begin waitPhase = ~waitPhase; avmWaitRequest = waitPhase; end
            2: avmWaitRequest = ($urandom_range(0, 2) == 0);
            default: avmWaitRequest = 1'b0;
        endcase
        if (prevStall && (avmAddress != prevAddr || avmWriteData != prevWd ||
                          avmRead != prevRd || avmWrite != prevWr)) stableErr++;
        if (avmRead && avmWrite) overlapErr++;
        if ((avmRead || avmWrite) && firstCmdCyc < 0) firstCmdCyc = cyc;
        if (avmWrite && !avmWaitRequest) begin
            mem[avmAddress] = avmWriteData;
            wrCount++;
        end
        if (avmRead && !avmWaitRequest) begin
            rsp = mem[avmAddress];
            if (corruptAll || corruptMap[avmAddress]) rsp ^= 32'h0000_0100;
            rspData.push_back(rsp);
            rspDue.push_back(cyc + latency);
            rdCount++;
        end
        if (rspDue.size() > maxInflight) maxInflight = rspDue.size();
        prevStall = (avmRead || avmWrite) && avmWaitRequest;
        prevAddr  = avmAddress;
        prevWd    = avmWriteData;
        prevRd    = avmRead;
        prevWr    = avmWrite;
    end

    task automatic clearCorrupt();
        for (int i = 0; i < DEPTH; i++) corruptMap[i] = 1'b0;
    endtask

    // One complete test; restartAt > 0 pulses a stray start that many cycles into the run.
    task automatic applyStimulus(input int base, input int count, input logic [31:0] seedV,
                                 input int wm, input int lat, input int restartAt);
        int expErr, expFirst, addr, startCyc, doneCyc, budget, mism;
        logic [31:0] expWord;
        expErr   = 0;
        expFirst = 0;
        for (int i = 0; i < count; i++) begin
            addr = (base + i) % DEPTH;
            if (corruptMap[addr]) begin
                if (expErr == 0) expFirst = addr;
                expErr++;
            end
        end
        expErr = expErr * PASSES;

        @(posedge clk);
        #1;
        waitMode    = wm;
        latency     = lat;
        wrCount     = 0;
        rdCount     = 0;
        maxInflight = 0;
        stableErr   = 0;
        overlapErr  = 0;
        firstCmdCyc = -1;
        lastRdvCyc  = -1;

        @(negedge clk);
        baseAddr  = AW'(base);
        wordCount = (AW+1)'(count);
        seed      = seedV;
        start     = 1'b1;
        startCyc  = cyc;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);

        doneCyc = -1;
        budget  = 300 + count * PASSES * (lat + 8) * 4;
        for (int k = 1; k < budget; k++) begin
            if (done) begin
                doneCyc = cyc;
                break;
            end
            if (k == restartAt) begin
                baseAddr  = AW'($urandom);
                wordCount = (AW+1)'(3);
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        checkOutput("done_timeout", doneCyc >= 0, 1);
        if (doneCyc >= 0) begin
            checkOutput("error_count", errorCount, expErr);
            checkOutput("pass", pass, expErr == 0);
            checkOutput("first_error_addr", firstErrorAddr, (expErr > 0) ? expFirst : 0);
            checkOutput("busy_at_done", busy, 0);
            checkOutput("write_count", wrCount, count * PASSES);
            checkOutput("read_count", rdCount, count * PASSES);
            checkOutput("rd_wr_overlap", overlapErr, 0);
            checkOutput("stall_stability", stableErr, 0);
            checkOutput("max_outstanding_ok", maxInflight <= MAXP, 1);
            if (count > 0) begin
                checkOutput("first_cmd_latency", firstCmdCyc - startCyc, 1);
                checkOutput("done_after_last_rdv", doneCyc - lastRdvCyc, 1);
            end else begin
                checkOutput("zero_count_done_latency", doneCyc - startCyc, 2);
            end
            if (wm == 0 && lat == 1 && count > 0)
                checkOutput("full_speed_cycles", doneCyc - startCyc, PASSES * (2 * count + 1) + 1);
            mism = 0;
            for (int i = 0; i < count; i++) begin
                expWord = seedV + 32'(i) * GOLD;
                expWord = (PASSES == 2) ? ~expWord : expWord;
                if (mem[(base + i) % DEPTH] !== expWord) mism++;
            end
            checkOutput("mem_content", mism, 0);
        end
    endtask

    initial begin
        int s, base, count, nc;
        logic [31:0] word3;
        reset     = 1'b1;
        start     = 1'b0;
        baseAddr  = '0;
        wordCount = '0;
        seed      = '0;
        clearCorrupt();
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_pass", pass, 0);
        checkOutput("reset_error_count", errorCount, 0);
        checkOutput("reset_first_error", firstErrorAddr, 0);
        checkOutput("reset_read", avmRead, 0);
        checkOutput("reset_write", avmWrite, 0);
        checkOutput("reset_address", avmAddress, 0);
        checkOutput("reset_writedata", avmWriteData, 0);
        checkOutput("reset_byteenable", avmByteEnable, 4'hF);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] zero-wait, latency 1, base 0, count 16, seed 0");
        applyStimulus(0, 16, 32'h0, 0, 1, 0);
        word3 = 32'd3 * GOLD;
        checkOutput("word3_pattern", mem[3], (PASSES == 2) ? ~word3 : word3);

        $display("[TB] alternating waitrequest");
        applyStimulus(200, 20, $urandom, 1, 2, 0);

        $display("[TB] corrupted words 5 and 9 at base 100");
        corruptMap[105] = 1'b1;
        corruptMap[109] = 1'b1;
        applyStimulus(100, 16, $urandom, 0, 1, 0);
        clearCorrupt();

        $display("[TB] latency 6 with a stray start mid-run");
        applyStimulus(500, 24, $urandom, 0, 6, 10);

        $display("[TB] address wrap-around");
        applyStimulus(16380, 8, $urandom, 0, 1, 0);

        $display("[TB] zero word count");
        applyStimulus(0, 0, $urandom, 0, 1, 0);

        $display("[TB] reset during READ with reads outstanding");
        @(posedge clk);
        #1;
        waitMode   = 0;
        latency    = 6;
        corruptAll = 1'b1;
        @(negedge clk);
        baseAddr  = AW'(0);
        wordCount = (AW+1)'(16);
        seed      = $urandom;
        start     = 1'b1;
        s         = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && cyc < s + 20; k++) @(negedge clk);
        checkOutput("mid_read_before_reset", avmRead, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_read", avmRead, 0);
        checkOutput("abort_write", avmWrite, 0);
        checkOutput("abort_address", avmAddress, 0);
        checkOutput("abort_writedata", avmWriteData, 0);
        checkOutput("abort_byteenable", avmByteEnable, 4'hF);
        repeat (15) @(negedge clk);
        checkOutput("abort_responses_drained", rspDue.size(), 0);
        checkOutput("abort_error_count", errorCount, 0);
        checkOutput("abort_first_error", firstErrorAddr, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_pass", pass, 0);
        corruptAll = 1'b0;
        applyStimulus(300, 12, $urandom, 0, 1, 0);

        $display("[TB] randomized runs");
        for (int t = 0; t < 6; t++) begin
            base  = $urandom_range(0, DEPTH - 1);
            count = $urandom_range(1, 40);
            nc    = $urandom_range(0, 2);
            for (int j = 0; j < nc; j++)
                corruptMap[(base + $urandom_range(0, count - 1)) % DEPTH] = 1'b1;
            applyStimulus(base, count, $urandom, $urandom_range(0, 2), $urandom_range(1, 7), 0);
            clearCorrupt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
